// File: rtl/sipo_ctrl.sv
// Sequencing controller for a WIDTH-bit SIPO: frames serial bits, captures the word, valid/ready output.
// Optional even-parity bit per frame when SIPO_CTRL_PARITY_EN is defined.
module sipo_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    input  logic [WIDTH-1:0] i_sipo_q,
    output logic             o_shift_en,
    output logic             o_sipo_clr,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_parity_err,
    input  logic             i_clr_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SIPO_CTRL_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_PARITY  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd3
    } state_t;
`endif

    state_t             r_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_sipo_clr;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_busy;
    logic               r_overrun;

    logic w_shift;
    logic w_last;
    logic w_capture;
    logic w_load;
    logic w_drop;
    logic w_consume;

    assign w_shift   = (r_state == ST_SHIFT) && i_sin_valid;
    assign w_last    = (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_capture = (r_state == ST_CAPTURE) && !i_abort;
    assign w_load    = w_capture && (!r_dout_valid || i_dout_ready);
    assign w_drop    = w_capture && r_dout_valid && !i_dout_ready;
    assign w_consume = r_dout_valid && i_dout_ready;

`ifdef SIPO_CTRL_PARITY_EN
    logic r_par_acc;
    logic r_parity_err;
    logic w_par_fail;

    // Even parity: data bits XOR parity bit must be zero.
    assign w_par_fail = (r_state == ST_PARITY) && !i_abort && i_sin_valid
                        && (i_sin ^ r_par_acc);
`else
    logic w_unused_sin;

    assign w_unused_sin = i_sin;
`endif

    // Frame sequencer, output port and sticky error flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_sipo_clr   <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SIPO_CTRL_PARITY_EN
            r_par_acc    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sipo_clr <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_sipo_clr <= 1'b1;
                        r_bit_cnt  <= '0;
`ifdef SIPO_CTRL_PARITY_EN
                        r_par_acc  <= 1'b0;
`endif
                        r_state    <= ST_SHIFT;
                        r_busy     <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_sin_valid) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
`ifdef SIPO_CTRL_PARITY_EN
                        r_par_acc <= r_par_acc ^ i_sin;
                        if (w_last) begin
                            r_state <= ST_PARITY;
                        end
`else
                        if (w_last) begin
                            r_state <= ST_CAPTURE;
                        end
`endif
                    end
                end

`ifdef SIPO_CTRL_PARITY_EN
                ST_PARITY: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_sin_valid) begin
                        if (w_par_fail) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
`endif

                ST_CAPTURE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A load in the same cycle as a consume keeps the port valid.
            if (w_load) begin
                r_dout       <= i_sipo_q;
                r_dout_valid <= 1'b1;
            end else if (w_consume) begin
                r_dout_valid <= 1'b0;
            end

            r_overrun <= (r_overrun && !i_clr_err) || w_drop;
`ifdef SIPO_CTRL_PARITY_EN
            r_parity_err <= (r_parity_err && !i_clr_err) || w_par_fail;
`endif
        end
    end

    assign o_shift_en   = w_shift;
    assign o_sipo_clr   = r_sipo_clr;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = r_busy;
    assign o_overrun    = r_overrun;
`ifdef SIPO_CTRL_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_ctrl.sv
// Directed bench for sipo_ctrl (WIDTH=4) with a behavioural SIPO model on the serial path.
module tb_sipo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, sin, sin_valid, dout_ready, clr_err;
    logic [3:0] sipo_q = 4'd0;
    logic       shift_en, sipo_clr, dout_valid, busy, overrun, parity_err;
    logic [3:0] dout;

    int n_vec = 0;
    int n_err = 0;
    int n_clr = 0;
    int n_shift = 0;
    int base_clr, base_shift;

    sipo_ctrl #(.WIDTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_sin        (sin),
        .i_sin_valid  (sin_valid),
        .i_sipo_q     (sipo_q),
        .o_shift_en   (shift_en),
        .o_sipo_clr   (sipo_clr),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready),
        .o_busy       (busy),
        .o_overrun    (overrun),
        .o_parity_err (parity_err),
        .i_clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    // SIPO register model and strobe counters.
    always @(posedge clk) begin
        if (sipo_clr)      sipo_q <= 4'd0;
        else if (shift_en) sipo_q <= {sipo_q[2:0], sin};
        if (sipo_clr) n_clr   <= n_clr + 1;
        if (shift_en) n_shift <= n_shift + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame and send bits MSB first; leaves the bench in the CAPTURE cycle.
    task automatic send_frame(input logic [3:0] bits, input int gap, input bit bad_par);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_frame", 32'(busy), 32'd1);
        tick();
        for (int i = 3; i >= 0; i--) begin
            sin       = bits[i];
            sin_valid = 1'b1;
            tick();
            if (i == 2 && gap > 0) begin
                sin_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    #1;
                    check("stall_shift", 32'(shift_en), 32'd0);
                    tick();
                end
            end
        end
`ifdef SIPO_CTRL_PARITY_EN
        sin       = (^bits) ^ bad_par;
        sin_valid = 1'b1;
        #1;
        check("par_no_shift", 32'(shift_en), 32'd0);
        tick();
`else
        if (bad_par) sin = 1'b0;
`endif
        sin_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; sin = 1'b0;
        sin_valid = 1'b0; dout_ready = 1'b1; clr_err = 1'b0;
        #2;
        check("rst_shift_en", 32'(shift_en), 32'd0);
        check("rst_sipo_clr", 32'(sipo_clr), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic frame 1,0,0,1
        base_clr = n_clr; base_shift = n_shift;
        send_frame(4'b1001, 0, 1'b0);
        check("basic_busy_capture", 32'(busy), 32'd1);
        tick();
        check("basic_dout", 32'(dout), 32'h9);
        check("basic_valid", 32'(dout_valid), 32'd1);
        check("basic_busy_after", 32'(busy), 32'd0);
        check("basic_clr_pulses", 32'(n_clr - base_clr), 32'd1);
        check("basic_shift_cycles", 32'(n_shift - base_shift), 32'd4);
        tick();
        check("basic_valid_consumed", 32'(dout_valid), 32'd0);

        // Stall of 3 cycles between bits 2 and 3
        base_shift = n_shift;
        send_frame(4'b1001, 3, 1'b0);
        tick();
        check("stall_dout", 32'(dout), 32'h9);
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_shift_cycles", 32'(n_shift - base_shift), 32'd4);
        check("stall_overrun", 32'(overrun), 32'd0);
        check("stall_parity_err", 32'(parity_err), 32'd0);
        tick();

        // Overrun: consumer stalled, second word dropped
        dout_ready = 1'b0;
        send_frame(4'b1100, 0, 1'b0);
        tick();
        check("ovr_first_dout", 32'(dout), 32'hC);
        check("ovr_first_valid", 32'(dout_valid), 32'd1);
        send_frame(4'b0011, 0, 1'b0);
        tick();
        check("ovr_dout_kept", 32'(dout), 32'hC);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid_kept", 32'(dout_valid), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        check("ovr_dout_after_clr", 32'(dout), 32'hC);
        dout_ready = 1'b1;
        tick();
        check("ovr_drained", 32'(dout_valid), 32'd0);

        // Abort after two bits, then a full frame
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sin = 1'b1; sin_valid = 1'b1;
        tick();
        sin = 1'b0;
        tick();
        sin_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        tick();
        send_frame(4'b0110, 0, 1'b0);
        tick();
        check("post_abort_dout", 32'(dout), 32'h6);
        check("post_abort_valid", 32'(dout_valid), 32'd1);
        tick();

        // Abort during the CAPTURE cycle drops the word
        send_frame(4'b1111, 0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("capt_abort_valid", 32'(dout_valid), 32'd0);
        check("capt_abort_dout", 32'(dout), 32'h6);
        check("capt_abort_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-frame
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sin = 1'b1; sin_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_shift_en", 32'(shift_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_sipo_clr", 32'(sipo_clr), 32'd0);
        sin_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

`ifdef SIPO_CTRL_PARITY_EN
        // Good parity bit
        send_frame(4'b1011, 0, 1'b0);
        tick();
        check("par_ok_dout", 32'(dout), 32'hB);
        check("par_ok_valid", 32'(dout_valid), 32'd1);
        check("par_ok_err", 32'(parity_err), 32'd0);
        tick();
        // Bad parity bit
        base_shift = n_shift;
        send_frame(4'b1011, 0, 1'b1);
        check("par_bad_err", 32'(parity_err), 32'd1);
        check("par_bad_busy", 32'(busy), 32'd0);
        tick();
        check("par_bad_valid", 32'(dout_valid), 32'd0);
        check("par_bad_shifts", 32'(n_shift - base_shift), 32'd4);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("par_err_cleared", 32'(parity_err), 32'd0);
`else
        check("par_tied_low", 32'(parity_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
